// File: rtl/ram_access_arbiter_pkg.sv
// Shared encodings for the RAM access arbiter: FSM states, grant owners,
// RAM access sizes and read/write direction.
package ram_access_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      GNT_NONE  = 2'b00,
      GNT_TRAP  = 2'b01,
      GNT_DATA  = 2'b10,
      GNT_FETCH = 2'b11
   } grant_e;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_e;

   typedef enum logic {
      RW_WRITE = 1'b0,
      RW_READ  = 1'b1
   } rw_e;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester and RAM handshake signals of the arbiter. The slave modport is the
// arbiter's view; the master modport is the requesters plus the RAM.
interface ram_access_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              trapReq;
   logic [ADDR_W-1:0] trapAddr;
   logic              trapAck;
   logic              dataReq;
   logic              dataRW;
   logic [1:0]        dataSize;
   logic [ADDR_W-1:0] dataAddr;
   logic [DATA_W-1:0] dataWdata;
   logic              dataAck;
   logic              fetchReq;
   logic [ADDR_W-1:0] fetchAddr;
   logic              fetchAck;
   logic [DATA_W-1:0] rdata;
   logic              busError;
   logic [1:0]        grantId;
   logic              ramMFA;
   logic              ramRW;
   logic [ADDR_W-1:0] ramAddress;
   logic [DATA_W-1:0] ramDataIn;
   logic [1:0]        ramDataSize;
   logic              ramMFC;
   logic [DATA_W-1:0] ramDataOut;

   modport slave (
      input  trapReq, trapAddr, dataReq, dataRW, dataSize, dataAddr, dataWdata,
             fetchReq, fetchAddr, ramMFC, ramDataOut,
      output trapAck, dataAck, fetchAck, rdata, busError, grantId,
             ramMFA, ramRW, ramAddress, ramDataIn, ramDataSize
   );

   modport master (
      output trapReq, trapAddr, dataReq, dataRW, dataSize, dataAddr, dataWdata,
             fetchReq, fetchAddr, ramMFC, ramDataOut,
      input  trapAck, dataAck, fetchAck, rdata, busError, grantId,
             ramMFA, ramRW, ramAddress, ramDataIn, ramDataSize
   );
endinterface

// File: rtl/ram_access_arbiter_mfc_timeout_counter.sv
// Counts cycles spent waiting for MFC; expired_o flags the last allowed cycle
// so the arbiter can abandon the access as a bus error.
module ram_access_arbiter_mfc_timeout_counter #(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic Clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   logic [TO_W-1:0] count_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of always_ff evaluation order.
   always_ff @(posedge Clk) begin
      if (reset || clear_i) begin
         count_q <= '0;
      end else if (enable_i) begin
         count_q <= count_q + TO_W'(1);
      end
   end

   assign expired_o = enable_i && (count_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/ram_access_arbiter.sv
// Fixed-priority (trap > data > fetch) arbiter sharing one RAM port, one access
// in flight, with a registered RAM handshake and an MFC timeout.
module ram_access_arbiter
   import ram_access_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input logic                 Clk,
   input logic                 reset,
   ram_access_arbiter_if.slave bus
);
   state_e            state_q, state_d;
   grant_e            grant_q, grant_d;
   rw_e               rw_q, rw_d;
   size_e             size_q, size_d;
   logic              mfa_q, mfa_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              trap_ack_q, trap_ack_d;
   logic              data_ack_q, data_ack_d;
   logic              fetch_ack_q, fetch_ack_d;
   logic              berr_q, berr_d;
   logic              finish;
   logic              expired;

   ram_access_arbiter_mfc_timeout_counter #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timeout (
      .Clk       (Clk),
      .reset     (reset),
      .clear_i   (state_q == ST_DONE),
      .enable_i  (state_q == ST_ACCESS),
      .expired_o (expired)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_d = state_q;
      grant_d = grant_q;
      rw_d    = rw_q;
      size_d  = size_q;
      mfa_d   = mfa_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      berr_d  = 1'b0;
      finish  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.trapReq) begin
               grant_d = GNT_TRAP;
               rw_d    = RW_READ;
               size_d  = SIZE_WORD;
               addr_d  = bus.trapAddr;
            end else if (bus.dataReq) begin
               grant_d = GNT_DATA;
               rw_d    = rw_e'(bus.dataRW);
               size_d  = size_e'(bus.dataSize);
               addr_d  = bus.dataAddr;
               wdata_d = bus.dataWdata;
            end else if (bus.fetchReq) begin
               grant_d = GNT_FETCH;
               rw_d    = RW_READ;
               size_d  = SIZE_WORD;
               addr_d  = bus.fetchAddr;
            end
            if (bus.trapReq || bus.dataReq || bus.fetchReq) begin
               mfa_d   = 1'b1;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // MFC takes precedence over a timeout expiring in the same cycle.
            if (bus.ramMFC) begin
               if (rw_q == RW_READ) rdata_d = bus.ramDataOut;
               finish = 1'b1;
            end else if (expired) begin
               rdata_d = '0;
               berr_d  = 1'b1;
               finish  = 1'b1;
            end
            if (finish) begin
               mfa_d   = 1'b0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            grant_d = GNT_NONE;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      trap_ack_d  = finish && (grant_q == GNT_TRAP);
      data_ack_d  = finish && (grant_q == GNT_DATA);
      fetch_ack_d = finish && (grant_q == GNT_FETCH);
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         grant_q     <= GNT_NONE;
         rw_q        <= RW_READ;
         size_q      <= SIZE_BYTE;
         mfa_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         trap_ack_q  <= 1'b0;
         data_ack_q  <= 1'b0;
         fetch_ack_q <= 1'b0;
         berr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rw_q        <= rw_d;
         size_q      <= size_d;
         mfa_q       <= mfa_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         trap_ack_q  <= trap_ack_d;
         data_ack_q  <= data_ack_d;
         fetch_ack_q <= fetch_ack_d;
         berr_q      <= berr_d;
      end
   end

   assign bus.trapAck     = trap_ack_q;
   assign bus.dataAck     = data_ack_q;
   assign bus.fetchAck    = fetch_ack_q;
   assign bus.busError    = berr_q;
   assign bus.rdata       = rdata_q;
   assign bus.grantId     = grant_q;
   assign bus.ramMFA      = mfa_q;
   assign bus.ramRW       = rw_q;
   assign bus.ramAddress  = addr_q;
   assign bus.ramDataIn   = wdata_q;
   assign bus.ramDataSize = size_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: a vector table for single accesses
// plus hand-written sequences for priority, timeout and reset corner cases.
module tb_ram_access_arbiter;
   import ram_access_arbiter_pkg::*;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   ram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ram_access_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(16),
      .TO_W   (5)
   ) dut (
      .Clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        trap, data, fetch;
      logic        d_rw;
      logic [1:0]  d_size;
      logic [8:0]  t_addr, d_addr, f_addr;
      logic [31:0] wdata, rd;
      logic [1:0]  e_grant;
      logic        e_rw;
      logic [1:0]  e_size;
      logic [8:0]  e_addr;
      logic        chk_din;
      logic [2:0]  e_ack;    // {trap, data, fetch}
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drops requests once sampled, answers MFC on the mfc_at-th MFA-high cycle
   // (0 = never) and returns when any ack is seen or the cycle budget runs out.
   task automatic run_access(input int mfc_at, input logic [31:0] rd,
                             output int mfa_cycles, output logic [2:0] acks,
                             output logic berr, output logic [1:0] grant0);
      mfa_cycles = 0;
      acks       = 3'b000;
      berr       = 1'b0;
      grant0     = 2'b00;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (c == 0) grant0 = bus.grantId;
         bus.trapReq  = 1'b0;
         bus.dataReq  = 1'b0;
         bus.fetchReq = 1'b0;
         acks = {bus.trapAck, bus.dataAck, bus.fetchAck};
         if (acks != 3'b000) begin
            berr       = bus.busError;
            bus.ramMFC = 1'b0;
            return;
         end
         if (bus.ramMFA) mfa_cycles++;
         bus.ramMFC     = bus.ramMFA && (mfa_cycles == mfc_at);
         bus.ramDataOut = rd;
      end
   endtask

   int         mfa_n, n_t, n_d, n_f, n_ord, mfa_bad;
   logic [2:0] acks;
   logic       berr;
   logic [1:0] g0;
   logic [1:0] order [3];

   initial begin
      //            t     d     f     rw    size   taddr   daddr   faddr   wdata         rd            grant  rw    size   addr    din   ack     rdata
      vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 9'h000, 9'h000, 9'h004, 32'h0000_0000, 32'h8C22_0000, 2'b11, 1'b1, 2'b10, 9'h004, 1'b0, 3'b001, 32'h8C22_0000};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 9'h000, 9'h010, 9'h000, 32'h0000_ABCD, 32'hDEAD_BEEF, 2'b10, 1'b0, 2'b01, 9'h010, 1'b1, 3'b010, 32'h8C22_0000};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 9'h1FC, 9'h000, 9'h000, 32'h0000_0000, 32'h0000_0100, 2'b01, 1'b1, 2'b10, 9'h1FC, 1'b0, 3'b100, 32'h0000_0100};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 9'h000, 9'h123, 9'h000, 32'h0000_0055, 32'h0000_007F, 2'b10, 1'b1, 2'b00, 9'h123, 1'b1, 3'b010, 32'h0000_007F};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 9'h008, 9'h0F0, 9'h0A0, 32'h1234_5678, 32'h1111_2222, 2'b01, 1'b1, 2'b10, 9'h008, 1'b0, 3'b100, 32'h1111_2222};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 9'h000, 9'h040, 9'h0AC, 32'hCAFE_F00D, 32'h3333_4444, 2'b10, 1'b1, 2'b10, 9'h040, 1'b1, 3'b010, 32'h3333_4444};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 9'h000, 9'h1FE, 9'h0B0, 32'h0F0F_0F0F, 32'h9999_9999, 2'b10, 1'b0, 2'b10, 9'h1FE, 1'b1, 3'b010, 32'h3333_4444};
      vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 9'h000, 9'h055, 9'h1F0, 32'hFFFF_FFFF, 32'h7654_3210, 2'b11, 1'b1, 2'b10, 9'h1F0, 1'b0, 3'b001, 32'h7654_3210};

      reset          = 1'b1;
      bus.trapReq    = 1'b0;
      bus.trapAddr   = '0;
      bus.dataReq    = 1'b0;
      bus.dataRW     = 1'b1;
      bus.dataSize   = 2'b00;
      bus.dataAddr   = '0;
      bus.dataWdata  = '0;
      bus.fetchReq   = 1'b0;
      bus.fetchAddr  = '0;
      bus.ramMFC     = 1'b0;
      bus.ramDataOut = '0;
      tick();
      tick();

      check("reset mfa",   bus.ramMFA, 0);
      check("reset rw",    bus.ramRW, 1);
      check("reset addr",  bus.ramAddress, 0);
      check("reset din",   bus.ramDataIn, 0);
      check("reset size",  bus.ramDataSize, 0);
      check("reset grant", bus.grantId, 0);
      check("reset rdata", bus.rdata, 0);
      check("reset acks",  {bus.trapAck, bus.dataAck, bus.fetchAck, bus.busError}, 0);
      reset = 1'b0;

      // MFC while idle must not start anything or touch rdata.
      bus.ramMFC     = 1'b1;
      bus.ramDataOut = 32'h5555_AAAA;
      tick();
      tick();
      check("idle mfc mfa",   bus.ramMFA, 0);
      check("idle mfc acks",  {bus.trapAck, bus.dataAck, bus.fetchAck}, 0);
      check("idle mfc rdata", bus.rdata, 0);
      bus.ramMFC = 1'b0;

      for (int i = 0; i < 8; i++) begin
         bus.trapReq   = vecs[i].trap;
         bus.dataReq   = vecs[i].data;
         bus.fetchReq  = vecs[i].fetch;
         bus.dataRW    = vecs[i].d_rw;
         bus.dataSize  = vecs[i].d_size;
         bus.trapAddr  = vecs[i].t_addr;
         bus.dataAddr  = vecs[i].d_addr;
         bus.fetchAddr = vecs[i].f_addr;
         bus.dataWdata = vecs[i].wdata;
         tick();
         check($sformatf("v%0d grant", i), bus.grantId, vecs[i].e_grant);
         check($sformatf("v%0d mfa", i), bus.ramMFA, 1);
         check($sformatf("v%0d rw", i), bus.ramRW, vecs[i].e_rw);
         check($sformatf("v%0d size", i), bus.ramDataSize, vecs[i].e_size);
         check($sformatf("v%0d addr", i), bus.ramAddress, vecs[i].e_addr);
         if (vecs[i].chk_din) check($sformatf("v%0d din", i), bus.ramDataIn, vecs[i].wdata);
         // Withdrawing the request mid-access must not cancel it.
         bus.trapReq    = 1'b0;
         bus.dataReq    = 1'b0;
         bus.fetchReq   = 1'b0;
         bus.ramMFC     = 1'b1;
         bus.ramDataOut = vecs[i].rd;
         tick();
         check($sformatf("v%0d ack", i), {bus.trapAck, bus.dataAck, bus.fetchAck}, vecs[i].e_ack);
         check($sformatf("v%0d mfa done", i), bus.ramMFA, 0);
         check($sformatf("v%0d rdata", i), bus.rdata, vecs[i].e_rdata);
         check($sformatf("v%0d berr", i), bus.busError, 0);
         bus.ramMFC     = 1'b0;
         bus.ramDataOut = '0;
         tick();
         check($sformatf("v%0d idle grant", i), bus.grantId, 0);
         check($sformatf("v%0d idle acks", i), {bus.trapAck, bus.dataAck, bus.fetchAck}, 0);
      end

      // Fetch with MFC on the second access cycle.
      bus.fetchAddr = 9'h004;
      bus.fetchReq  = 1'b1;
      run_access(2, 32'h8C22_0000, mfa_n, acks, berr, g0);
      check("t1 grant",      g0, GNT_FETCH);
      check("t1 mfa cycles", mfa_n, 2);
      check("t1 ack",        acks, 3'b001);
      check("t1 berr",       berr, 0);
      check("t1 rdata",      bus.rdata, 32'h8C22_0000);
      tick();
      check("t1 grant after", bus.grantId, 0);
      check("t1 ack after",   bus.fetchAck, 0);

      // All three requesters at once: served trap, data, fetch, one ack each.
      bus.trapAddr   = 9'h018;
      bus.dataAddr   = 9'h0C0;
      bus.dataRW     = 1'b1;
      bus.dataSize   = 2'b10;
      bus.fetchAddr  = 9'h100;
      bus.ramDataOut = 32'h1357_9BDF;
      bus.trapReq    = 1'b1;
      bus.dataReq    = 1'b1;
      bus.fetchReq   = 1'b1;
      n_t = 0; n_d = 0; n_f = 0; n_ord = 0; mfa_bad = 0;
      for (int k = 0; k < 3; k++) order[k] = GNT_NONE;
      for (int c = 0; c < 40; c++) begin
         tick();
         if ((bus.trapAck || bus.dataAck || bus.fetchAck) && bus.ramMFA) mfa_bad++;
         if (bus.trapAck) begin
            n_t++; bus.trapReq = 1'b0;
            if (n_ord < 3) order[n_ord] = GNT_TRAP;
            n_ord++;
         end
         if (bus.dataAck) begin
            n_d++; bus.dataReq = 1'b0;
            if (n_ord < 3) order[n_ord] = GNT_DATA;
            n_ord++;
         end
         if (bus.fetchAck) begin
            n_f++; bus.fetchReq = 1'b0;
            if (n_ord < 3) order[n_ord] = GNT_FETCH;
            n_ord++;
         end
         bus.ramMFC = bus.ramMFA;
      end
      bus.ramMFC = 1'b0;
      check("t3 trap acks",  n_t, 1);
      check("t3 data acks",  n_d, 1);
      check("t3 fetch acks", n_f, 1);
      check("t3 order0",     order[0], GNT_TRAP);
      check("t3 order1",     order[1], GNT_DATA);
      check("t3 order2",     order[2], GNT_FETCH);
      check("t3 mfa at ack", mfa_bad, 0);
      check("t3 rdata",      bus.rdata, 32'h1357_9BDF);

      // Data read with no MFC: times out after 16 access cycles.
      bus.dataAddr = 9'h020;
      bus.dataRW   = 1'b1;
      bus.dataSize = 2'b10;
      bus.dataReq  = 1'b1;
      run_access(0, 32'hFFFF_FFFF, mfa_n, acks, berr, g0);
      check("t4 grant",      g0, GNT_DATA);
      check("t4 mfa cycles", mfa_n, 16);
      check("t4 ack",        acks, 3'b010);
      check("t4 berr",       berr, 1);
      check("t4 rdata",      bus.rdata, 0);
      tick();
      check("t4 berr after", bus.busError, 0);
      check("t4 ack after",  bus.dataAck, 0);

      // MFC arrives on the very cycle the timeout expires: MFC wins.
      bus.dataAddr = 9'h024;
      bus.dataReq  = 1'b1;
      run_access(16, 32'hA5A5_5A5A, mfa_n, acks, berr, g0);
      check("t6 mfa cycles", mfa_n, 16);
      check("t6 ack",        acks, 3'b010);
      check("t6 berr",       berr, 0);
      check("t6 rdata",      bus.rdata, 32'hA5A5_5A5A);
      tick();

      // Reset on the second access cycle of a fetch abandons it without an ack.
      bus.fetchAddr = 9'h0AC;
      bus.fetchReq  = 1'b1;
      tick();
      tick();
      check("t5 mfa before", bus.ramMFA, 1);
      reset = 1'b1;
      tick();
      check("t5 mfa",   bus.ramMFA, 0);
      check("t5 grant", bus.grantId, 0);
      check("t5 ack",   bus.fetchAck, 0);
      check("t5 addr",  bus.ramAddress, 0);
      check("t5 rdata", bus.rdata, 0);
      reset = 1'b0;
      tick();
      check("t5 restart grant", bus.grantId, GNT_FETCH);
      check("t5 restart mfa",   bus.ramMFA, 1);
      check("t5 restart addr",  bus.ramAddress, 9'h0AC);
      bus.fetchReq   = 1'b0;
      bus.ramMFC     = 1'b1;
      bus.ramDataOut = 32'h0BAD_F00D;
      tick();
      check("t5 restart ack",   bus.fetchAck, 1);
      check("t5 restart rdata", bus.rdata, 32'h0BAD_F00D);
      bus.ramMFC = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
